// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - cache miss fill controller (optional CRITICAL_WORD_FIRST_EN)
module cache_fill_ctrl #(
    parameter int BLOCKS = 128,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [15:0]       miss_address,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data_out,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [15:0]       mem_address,
    output logic              write_data_array,
    output logic [BLOCKS-1:0] block_enable,
    output logic [WORDS-1:0]  word_enable,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              critical_word_ready,
`endif
    output logic [15:0]       data_out,
    output logic              write_tag_array
);
    localparam int IW = $clog2(BLOCKS);
    localparam int OW = $clog2(WORDS);
    localparam logic [OW-1:0] LAST = OW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state;
    logic [OW-1:0] issue_cnt;
    logic          issue_done;
    logic [OW-1:0] rx_cnt;
    logic [15:0]   base;
    logic [OW-1:0] start;
    logic [OW-1:0] issue_word;
    logic [OW-1:0] rx_word;
    logic          in_fill;
    logic          unused_addr_bits;

    // Sequencer: latch the block base on a miss, count issued reads and returned words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            issue_done <= 1'b0;
            rx_cnt     <= '0;
            base       <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            start      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base       <= {miss_address[15:OW+1], (OW+1)'(0)};
`ifdef CRITICAL_WORD_FIRST_EN
                        start      <= miss_address[OW:1];
`endif
                        issue_cnt  <= '0;
                        issue_done <= 1'b0;
                        rx_cnt     <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (!issue_done) begin
                        if (issue_cnt == LAST) issue_done <= 1'b1;
                        else                   issue_cnt  <= issue_cnt + 1'b1;
                    end
                    if (mem_data_valid) begin
                        if (rx_cnt == LAST) state  <= DONE;
                        else                rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CRITICAL_WORD_FIRST_EN
    assign start = '0;
`endif

    // Word order wraps modulo WORDS from the start offset (zero unless critical word first)
    always_comb begin
        issue_word = start + issue_cnt;
        rx_word    = start + rx_cnt;
        in_fill    = (state == FILL);
    end

    // Stall, memory issue and data-array write controls
    always_comb begin
        fsm_busy         = (state == IDLE) ? (miss_detected && !rst) : 1'b1;
        mem_read         = in_fill && !issue_done;
        mem_address      = mem_read ? (base | (16'(issue_word) << 1)) : 16'h0000;
        write_data_array = in_fill && mem_data_valid;
        block_enable     = write_data_array ? (BLOCKS'(1) << base[IW+OW:OW+1]) : '0;
        word_enable      = write_data_array ? (WORDS'(1) << rx_word) : '0;
        data_out         = write_data_array ? mem_data_out : 16'h0000;
        write_tag_array  = (state == DONE);
`ifdef CRITICAL_WORD_FIRST_EN
        critical_word_ready = write_data_array && (rx_cnt == '0);
`endif
    end

    // Byte/offset address bits are dropped from the latched base on purpose
    assign unused_addr_bits = ^{miss_address[OW:0], base[OW:0]};

endmodule
